// File: rtl/buffer_pkg.sv
// Shared definitions for the multi-bank memory buffer: access-mode encoding
// and default sizing constants.
package buffer_pkg;

    typedef enum logic [1:0] {
        SERIAL    = 2'd0,
        PARALLEL  = 2'd1,
        BROADCAST = 2'd2,
        RSVD      = 2'd3
    } mode_e;

    localparam int DEF_N_BUF = 6;
    localparam int DEF_WID   = 16;
    localparam int DEF_DEPTH = 256;

endpackage

// File: rtl/buffer_bank.sv
// One memory bank: a single write port and a single synchronous, read-first read port.
// Contents are never reset; the read register only updates when a read is issued.
module buffer_bank #(
    parameter  int WID    = 16,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WID-1:0]    w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [WID-1:0]    r_data
);

    logic [WID-1:0] mem_q [DEPTH];
    logic [WID-1:0] r_data_d;
    logic [WID-1:0] r_data_q;

    // The read samples the array before this edge's write lands, giving old data on a collision.
    always_comb begin
        r_data_d = r_data_q;
        if (r_en) begin
            r_data_d = mem_q[r_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_q[w_addr] <= w_data;
        end
        r_data_q <= r_data_d;
    end

    assign r_data = r_data_q;

endmodule

// File: rtl/memory_buffer_param.sv
// N_BUF independent banks reachable through a serial (one-hot select) port, a per-lane
// parallel port, or a broadcast write; mode is sampled with each request.
module memory_buffer_param
    import buffer_pkg::*;
#(
    parameter  int N_BUF  = DEF_N_BUF,
    parameter  int WID    = DEF_WID,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [N_BUF-1:0]        m0_w_en,
    input  logic [N_BUF-1:0]        m0_r_en,
    input  logic [ADDR_W-1:0]       m0_w_addr,
    input  logic [ADDR_W-1:0]       m0_r_addr,
    input  logic [WID-1:0]          m0_w_data,
    output logic [WID-1:0]          m0_r_data,
    output logic                    m0_r_valid,
    input  logic [N_BUF-1:0]        m1_w_en,
    input  logic [N_BUF-1:0]        m1_r_en,
    input  logic [N_BUF*ADDR_W-1:0] m1_w_addr,
    input  logic [N_BUF*ADDR_W-1:0] m1_r_addr,
    input  logic [N_BUF*WID-1:0]    m1_input_bus,
    output logic [N_BUF*WID-1:0]    m1_output_bus,
    output logic [N_BUF-1:0]        m1_r_valid,
    input  logic                    err_clr,
    output logic                    err_onehot
);

    mode_e mode_s;
    logic  m0_w_multi;
    logic  m0_r_multi;

    logic [N_BUF-1:0]  bank_w_en;
    logic [N_BUF-1:0]  bank_r_en;
    logic [ADDR_W-1:0] bank_w_addr [N_BUF];
    logic [WID-1:0]    bank_w_data [N_BUF];
    logic [ADDR_W-1:0] bank_r_addr [N_BUF];
    logic [WID-1:0]    bank_r_data [N_BUF];
    logic              m0_rd_req;
    logic              err_set;

    logic                 m0_pend_d,   m0_pend_q;
    logic [N_BUF-1:0]     m0_sel_d,    m0_sel_q;
    logic [WID-1:0]       m0_hold_d,   m0_hold_q;
    logic [N_BUF-1:0]     lane_pend_d, lane_pend_q;
    logic [N_BUF*WID-1:0] lane_hold_d, lane_hold_q;
    logic                 err_d,       err_q;

    logic [WID-1:0]       m0_sel_data;
    logic [WID-1:0]       m0_data_s;
    logic [N_BUF*WID-1:0] lane_data_s;

    assign mode_s     = mode_e'(mode);
    assign m0_w_multi = ($countones(m0_w_en) > 1);
    assign m0_r_multi = ($countones(m0_r_en) > 1);

    // Request routing into the banks; everything is suppressed while reset is low.
    always_comb begin
        bank_w_en = '0;
        bank_r_en = '0;
        m0_rd_req = 1'b0;
        err_set   = 1'b0;
        for (int i = 0; i < N_BUF; i++) begin
            bank_w_addr[i] = m0_w_addr;
            bank_w_data[i] = m0_w_data;
            bank_r_addr[i] = m0_r_addr;
        end
        if (rst) begin
            case (mode_s)
                SERIAL: begin
                    err_set = m0_w_multi | m0_r_multi;
                    if (!m0_w_multi) begin
                        bank_w_en = m0_w_en;
                    end
                    if (!m0_r_multi) begin
                        bank_r_en = m0_r_en;
                        m0_rd_req = |m0_r_en;
                    end
                end
                PARALLEL: begin
                    bank_w_en = m1_w_en;
                    bank_r_en = m1_r_en;
                    for (int i = 0; i < N_BUF; i++) begin
                        bank_w_addr[i] = m1_w_addr[i*ADDR_W +: ADDR_W];
                        bank_w_data[i] = m1_input_bus[i*WID +: WID];
                        bank_r_addr[i] = m1_r_addr[i*ADDR_W +: ADDR_W];
                    end
                end
                BROADCAST: begin
                    bank_w_en = {N_BUF{|m0_w_en}};
                    bank_r_en = m1_r_en;
                    for (int i = 0; i < N_BUF; i++) begin
                        bank_r_addr[i] = m1_r_addr[i*ADDR_W +: ADDR_W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_BUF; g++) begin : g_bank
        buffer_bank #(
            .WID   (WID),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk    (clk),
            .w_en   (bank_w_en[g]),
            .w_addr (bank_w_addr[g]),
            .w_data (bank_w_data[g]),
            .r_en   (bank_r_en[g]),
            .r_addr (bank_r_addr[g]),
            .r_data (bank_r_data[g])
        );
    end

    // The serial select is captured with the request, so the response follows the bank
    // that was read even if mode changes on the next cycle.
    always_comb begin
        m0_sel_data = '0;
        for (int i = 0; i < N_BUF; i++) begin
            if (m0_sel_q[i]) begin
                m0_sel_data = m0_sel_data | bank_r_data[i];
            end
        end
        m0_data_s = m0_pend_q ? m0_sel_data : m0_hold_q;
        for (int i = 0; i < N_BUF; i++) begin
            lane_data_s[i*WID +: WID] = lane_pend_q[i] ? bank_r_data[i]
                                                       : lane_hold_q[i*WID +: WID];
        end
    end

    always_comb begin
        m0_pend_d   = m0_rd_req;
        m0_sel_d    = m0_rd_req ? m0_r_en : m0_sel_q;
        m0_hold_d   = m0_data_s;
        lane_pend_d = bank_r_en;
        lane_hold_d = lane_data_s;
        err_d       = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m0_pend_q   <= 1'b0;
            m0_sel_q    <= '0;
            m0_hold_q   <= '0;
            lane_pend_q <= '0;
            lane_hold_q <= '0;
            err_q       <= 1'b0;
        end else begin
            m0_pend_q   <= m0_pend_d;
            m0_sel_q    <= m0_sel_d;
            m0_hold_q   <= m0_hold_d;
            lane_pend_q <= lane_pend_d;
            lane_hold_q <= lane_hold_d;
            err_q       <= err_d;
        end
    end

    // Holding reset low blanks every output at once, so a response already in flight
    // when reset arrives never shows up as a valid pulse.
    assign m0_r_data     = rst ? m0_data_s : '0;
    assign m0_r_valid    = rst & m0_pend_q;
    assign m1_output_bus = rst ? lane_data_s : '0;
    assign m1_r_valid    = rst ? lane_pend_q : '0;
    assign err_onehot    = rst & err_q;

endmodule

// File: tb/tb_memory_buffer_param.sv
// Scoreboard bench for memory_buffer_param: drivers update a plain array model of the
// banks and queue expected responses; a negedge monitor pops and compares them.
module tb_memory_buffer_param;

    localparam int N_BUF  = 6;
    localparam int WID    = 16;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                    clk;
    logic                    rst;
    logic [1:0]              mode;
    logic [N_BUF-1:0]        m0_w_en, m0_r_en;
    logic [ADDR_W-1:0]       m0_w_addr, m0_r_addr;
    logic [WID-1:0]          m0_w_data;
    logic [WID-1:0]          m0_r_data;
    logic                    m0_r_valid;
    logic [N_BUF-1:0]        m1_w_en, m1_r_en;
    logic [N_BUF*ADDR_W-1:0] m1_w_addr, m1_r_addr;
    logic [N_BUF*WID-1:0]    m1_input_bus;
    logic [N_BUF*WID-1:0]    m1_output_bus;
    logic [N_BUF-1:0]        m1_r_valid;
    logic                    err_clr;
    logic                    err_onehot;

    memory_buffer_param #(.N_BUF(N_BUF), .WID(WID), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .m0_w_en       (m0_w_en),
        .m0_r_en       (m0_r_en),
        .m0_w_addr     (m0_w_addr),
        .m0_r_addr     (m0_r_addr),
        .m0_w_data     (m0_w_data),
        .m0_r_data     (m0_r_data),
        .m0_r_valid    (m0_r_valid),
        .m1_w_en       (m1_w_en),
        .m1_r_en       (m1_r_en),
        .m1_w_addr     (m1_w_addr),
        .m1_r_addr     (m1_r_addr),
        .m1_input_bus  (m1_input_bus),
        .m1_output_bus (m1_output_bus),
        .m1_r_valid    (m1_r_valid),
        .err_clr       (err_clr),
        .err_onehot    (err_onehot)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int             due;
        logic [WID-1:0] data;
    } exp_t;

    exp_t           m0_q [$];
    exp_t           lane_q [N_BUF][$];
    logic           exp_err_q [$];
    logic [WID-1:0] mdl [N_BUF][DEPTH];
    logic           err_mdl = 1'b0;
    logic [WID-1:0] last_m0 = '0;
    logic [WID-1:0] last_lane [N_BUF];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N_BUF-1:0] v);
        int r = 0;
        for (int i = 0; i < N_BUF; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference behaviour for the request currently on the inputs (reads before writes).
    task automatic model_step();
        exp_t e;
        logic viol = 1'b0;
        int   b;
        if (!rst) begin
            while (m0_q.size() > 0 && m0_q[0].due == cyc) void'(m0_q.pop_front());
            for (int i = 0; i < N_BUF; i++)
                while (lane_q[i].size() > 0 && lane_q[i][0].due == cyc) void'(lane_q[i].pop_front());
            err_mdl = 1'b0;
            exp_err_q.push_back(1'b0);
            return;
        end
        e.due = cyc + 1;
        case (mode)
            2'd0: begin
                if ($countones(m0_r_en) == 1) begin
                    b = onehot_idx(m0_r_en);
                    e.data = mdl[b][m0_r_addr];
                    m0_q.push_back(e);
                    lane_q[b].push_back(e);
                end else if ($countones(m0_r_en) > 1) viol = 1'b1;
                if ($countones(m0_w_en) == 1) mdl[onehot_idx(m0_w_en)][m0_w_addr] = m0_w_data;
                else if ($countones(m0_w_en) > 1) viol = 1'b1;
            end
            2'd1, 2'd2: begin
                for (int i = 0; i < N_BUF; i++) begin
                    if (m1_r_en[i]) begin
                        e.data = mdl[i][m1_r_addr[i*ADDR_W +: ADDR_W]];
                        lane_q[i].push_back(e);
                    end
                end
                for (int i = 0; i < N_BUF; i++) begin
                    if (mode == 2'd1 && m1_w_en[i])
                        mdl[i][m1_w_addr[i*ADDR_W +: ADDR_W]] = m1_input_bus[i*WID +: WID];
                    else if (mode == 2'd2 && m0_w_en != 0)
                        mdl[i][m0_w_addr] = m0_w_data;
                end
            end
            default: begin
            end
        endcase
        err_mdl = viol | (err_mdl & ~err_clr);
        exp_err_q.push_back(err_mdl);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        mode = 2'd0; err_clr = 1'b0;
        m0_w_en = '0; m0_r_en = '0; m0_w_addr = '0; m0_r_addr = '0; m0_w_data = '0;
        m1_w_en = '0; m1_r_en = '0; m1_w_addr = '0; m1_r_addr = '0; m1_input_bus = '0;
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic ser(input logic [N_BUF-1:0] w_en, input int wa, input logic [WID-1:0] wd,
                       input logic [N_BUF-1:0] r_en, input int ra, input logic clr);
        mode = 2'd0; m0_w_en = w_en; m0_w_addr = ADDR_W'(wa); m0_w_data = wd;
        m0_r_en = r_en; m0_r_addr = ADDR_W'(ra); err_clr = clr;
        do_cycle();
    endtask

    task automatic par_read(input logic [1:0] md, input int base, input int step);
        mode = md; m1_r_en = '1;
        for (int i = 0; i < N_BUF; i++) m1_r_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(base + step * i);
        do_cycle();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("rst_m0_valid", 64'(m0_r_valid), 64'd0);
            chk("rst_m0_data", 64'(m0_r_data), 64'd0);
            chk("rst_m1_valid", 64'(m1_r_valid), 64'd0);
            for (int i = 0; i < N_BUF; i++) chk("rst_m1_lane", 64'(m1_output_bus[i*WID +: WID]), 64'd0);
            chk("rst_err", 64'(err_onehot), 64'd0);
            last_m0 = '0;
            for (int i = 0; i < N_BUF; i++) last_lane[i] = '0;
            if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
        end else begin
            if (m0_q.size() > 0 && m0_q[0].due == cyc) begin
                e = m0_q.pop_front();
                chk("m0_valid", 64'(m0_r_valid), 64'd1);
                chk("m0_data", 64'(m0_r_data), 64'(e.data));
                last_m0 = e.data;
            end else begin
                chk("m0_valid_idle", 64'(m0_r_valid), 64'd0);
                chk("m0_hold", 64'(m0_r_data), 64'(last_m0));
            end
            for (int i = 0; i < N_BUF; i++) begin
                if (lane_q[i].size() > 0 && lane_q[i][0].due == cyc) begin
                    e = lane_q[i].pop_front();
                    chk("m1_valid", 64'(m1_r_valid[i]), 64'd1);
                    chk("m1_lane_data", 64'(m1_output_bus[i*WID +: WID]), 64'(e.data));
                    last_lane[i] = e.data;
                end else begin
                    chk("m1_valid_idle", 64'(m1_r_valid[i]), 64'd0);
                    chk("m1_lane_hold", 64'(m1_output_bus[i*WID +: WID]), 64'(last_lane[i]));
                end
            end
            if (exp_err_q.size() > 0) chk("err_onehot", 64'(err_onehot), 64'(exp_err_q.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N_BUF; i++) last_lane[i] = '0;
        rst = 1'b0;
        idle_inputs();
        repeat (3) do_cycle();
        rst = 1'b1;

        // Known contents for the address window used below.
        for (int a = 0; a < 32; a++) begin
            mode = 2'd2; m0_w_en = 6'b000001; m0_w_addr = ADDR_W'(a); m0_w_data = WID'($urandom);
            do_cycle();
        end
        ser(6'b000001, 7, 16'h0055, '0, 0, 1'b0);

        // Serial write then read of bank 3.
        ser(6'b001000, 5, 16'h1234, '0, 0, 1'b0);
        ser('0, 0, '0, 6'b001000, 5, 1'b0);

        // Non-one-hot write is dropped and flagged; clear with a clean request.
        ser(6'b000110, 5, 16'hDEAD, '0, 0, 1'b0);
        ser('0, 0, '0, 6'b000010, 5, 1'b0);
        ser('0, 0, '0, 6'b000100, 5, 1'b1);
        ser('0, 0, '0, 6'b010001, 3, 1'b0);
        ser(6'b000011, 9, 16'h7777, '0, 0, 1'b1);
        ser('0, 0, '0, '0, 0, 1'b1);

        // Parallel write of lane index to 10+i, then read back.
        mode = 2'd1; m1_w_en = '1;
        for (int i = 0; i < N_BUF; i++) begin
            m1_w_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(10 + i);
            m1_input_bus[i*WID +: WID] = WID'(i);
        end
        do_cycle();
        par_read(2'd1, 10, 1);

        // Broadcast write, parallel read of every lane.
        mode = 2'd2; m0_w_en = 6'b100000; m0_w_addr = '0; m0_w_data = 16'hBEEF;
        do_cycle();
        par_read(2'd1, 0, 0);

        // Same-cycle write/read collision returns old data, then new data.
        ser(6'b000001, 7, 16'h00AA, 6'b000001, 7, 1'b0);
        ser('0, 0, '0, 6'b000001, 7, 1'b0);

        // Reserved mode does nothing.
        mode = 2'd3; m0_w_en = 6'b000001; m0_r_en = 6'b000001; m1_w_en = '1; m1_r_en = '1;
        do_cycle();

        // Serial read followed by a mode change: response still lands on lane 1.
        ser('0, 0, '0, 6'b000010, 11, 1'b0);
        par_read(2'd1, 12, 1);

        // Read in flight when reset asserts; contents survive reset.
        ser('0, 0, '0, 6'b000100, 12, 1'b0);
        rst = 1'b0;
        do_cycle();
        rst = 1'b1;
        ser('0, 0, '0, 6'b001000, 5, 1'b0);
        par_read(2'd2, 10, 1);

        // Randomized traffic over a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            int sel;
            rst = ($urandom_range(0, 99) != 0);
            err_clr = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            mode = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            case ($urandom_range(0, 3))
                0: m0_w_en = '0;
                3: m0_w_en = N_BUF'($urandom_range(0, 63));
                default: m0_w_en = N_BUF'(1 << $urandom_range(0, N_BUF - 1));
            endcase
            case ($urandom_range(0, 3))
                0: m0_r_en = '0;
                3: m0_r_en = N_BUF'($urandom_range(0, 63));
                default: m0_r_en = N_BUF'(1 << $urandom_range(0, N_BUF - 1));
            endcase
            m0_w_addr = ADDR_W'($urandom_range(0, 31));
            m0_r_addr = ADDR_W'($urandom_range(0, 31));
            m0_w_data = WID'($urandom);
            m1_w_en = N_BUF'($urandom_range(0, 63));
            m1_r_en = N_BUF'($urandom_range(0, 63));
            for (int i = 0; i < N_BUF; i++) begin
                m1_w_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
                m1_r_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
                m1_input_bus[i*WID +: WID] = WID'($urandom);
            end
            do_cycle();
        end
        rst = 1'b1;
        repeat (4) do_cycle();

        chk("m0_queue_drained", 64'(m0_q.size()), 64'd0);
        for (int i = 0; i < N_BUF; i++) chk("lane_queue_drained", 64'(lane_q[i].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
